// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   NOP_INSTR       - instruction presented to decode when nothing is valid
//   PC_STEP         - byte increment between sequential fetches
//   FETCH_BUF_DEPTH - entries in the fetch output buffer
//   fetch_entry_t   - one buffered instruction together with its byte PC
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int          PC_STEP         = 4;
    localparam int          FETCH_BUF_DEPTH = 2;
    localparam int          BUF_CNT_W       = $clog2(FETCH_BUF_DEPTH + 1);

    // The entry PC field is sized for the widest supported address; narrower
    // PCs are zero-extended into it.
    localparam int          MAX_ADDR_WIDTH  = 32;

    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0] pc;
        logic [31:0]               instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-to-decode valid/ready channel.
//   if_valid - buffer head holds a valid instruction (fetch -> decode)
//   if_ready - decode accepts the head this cycle      (decode -> fetch)
//   if_instr - head instruction, NOP when not valid    (fetch -> decode)
//   if_pc    - byte PC of the head, 0 when not valid   (fetch -> decode)
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_valid;
    logic                  if_ready;
    logic [31:0]           if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;

    modport master (
        output if_valid,
        output if_instr,
        output if_pc,
        input  if_ready
    );

    modport slave (
        input  if_valid,
        input  if_instr,
        input  if_pc,
        output if_ready
    );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetch_entry_t between the PC/memory side and decode.
//   clk, rst  - clock, asynchronous active-high reset
//   push      - write wr_entry at the tail
//   pop       - drop the head
//   flush     - discard all entries; wins over push and pop
//   wr_entry  - entry to write on push
//   head      - current head entry (meaningful only when not empty)
//   full      - count == FETCH_BUF_DEPTH
//   empty     - count == 0
//   count     - number of valid entries
module fetch_buf
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  fetch_entry_t         wr_entry,
    output fetch_entry_t         head,
    output logic                 full,
    output logic                 empty,
    output logic [BUF_CNT_W-1:0] count
);

    fetch_entry_t         mem [FETCH_BUF_DEPTH];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [BUF_CNT_W-1:0] cnt_q;
    logic                 do_pop;
    logic                 do_push;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == BUF_CNT_W'(FETCH_BUF_DEPTH));
    assign count = cnt_q;
    assign head  = mem[rd_ptr];

    // When full, a simultaneous pop frees the slot the write pointer already
    // points at (the old head), so push-with-pop keeps order with no bypass.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + BUF_CNT_W'(do_push) - BUF_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational word-indexed
// program memory.
//   clk, rst        - clock, asynchronous active-high reset
//   fetch_en        - allow new fetches; buffer still drains when low
//   redirect_valid  - execute requests a PC change (flushes the buffer)
//   redirect_pc     - target byte PC, low two bits ignored
//   imem_address    - word index to memory, pc >> 2
//   imem_data       - memory read data for imem_address, same cycle
//   dec             - valid/ready channel to decode (master side)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]           imem_data,
    fetch_unit_if.master          dec
);

    logic [ADDR_WIDTH-1:0] pc;
    logic                  pop;
    logic                  push;
    fetch_entry_t          wr_entry;
    fetch_entry_t          head;
    logic                  buf_full;
    logic                  buf_empty;
    logic [BUF_CNT_W-1:0]  buf_count;
    logic                  unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_address = {2'b00, pc[ADDR_WIDTH-1:2]};

    // if_valid comes straight from buffer state, so pop never depends
    // combinationally on itself through the outputs.
    assign pop  = dec.if_valid & dec.if_ready;
    assign push = fetch_en & ~redirect_valid & (~buf_full | pop);

    assign wr_entry.pc    = MAX_ADDR_WIDTH'(pc);
    assign wr_entry.instr = imem_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    fetch_buf u_fetch_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    // Outputs are muxed from registered buffer state only.
    assign dec.if_valid = ~buf_empty;
    assign dec.if_instr = buf_empty ? NOP_INSTR : head.instr;
    assign dec.if_pc    = buf_empty ? '0 : head.pc[ADDR_WIDTH-1:0];

    a_count_in_range : assert property (
        @(posedge clk) disable iff (rst) buf_count <= BUF_CNT_W'(FETCH_BUF_DEPTH)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [31:0]   imem_address;
    logic [31:0]   imem_data;
    logic          ready = 1'b0;

    fetch_unit_if #(.ADDR_WIDTH(AW)) dec ();

    fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_address   (imem_address),
        .imem_data      (imem_data),
        .dec            (dec)
    );

    always #5 clk = ~clk;

    // program memory: word k holds 0x1000 + k
    assign imem_data   = 32'h0000_1000 + imem_address;
    assign dec.if_ready = ready;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer as a queue of {pc, instr}, pc as plain integer.
    typedef struct {
        int unsigned pc;
        int unsigned instr;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned m_pc = 0;

    // Stimulus side: at each edge decide what the fetch stage must have done.
    // Any head already handed over by the monitor has been removed, so a free
    // slot exists exactly when fewer than two entries remain.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_pc = 0;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (fetch_en && exp_q.size() < 2) begin
            exp_q.push_back('{m_pc, 32'h0000_1000 + (m_pc >> 2)});
            m_pc = m_pc + 4;
        end
    end

    // Monitor: compare outputs to the expected head, consume it on handshake.
    always @(negedge clk) begin
        check("imem_address", imem_address, m_pc >> 2);
        if (exp_q.size() > 0) begin
            check("if_valid", dec.if_valid, 1);
            check("if_pc", dec.if_pc, exp_q[0].pc);
            check("if_instr", dec.if_instr, exp_q[0].instr);
            if (ready && !rst) void'(exp_q.pop_front());
        end else begin
            check("if_valid_idle", dec.if_valid, 0);
            check("if_instr_idle", dec.if_instr, NOP_INSTR);
            check("if_pc_idle", dec.if_pc, 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    initial begin
        ready    = 1'b1;
        fetch_en = 1'b1;
        do_reset();

        // sequential fetch
        cyc();
        check("first_valid", dec.if_valid, 1);
        check("first_pc", dec.if_pc, 32'h0);
        check("first_instr", dec.if_instr, 32'h1000);
        repeat (3) cyc();
        check("seq_pc", dec.if_pc, 32'hC);
        check("seq_instr", dec.if_instr, 32'h1003);

        // backpressure
        do_reset();
        cyc();
        ready = 1'b0;
        repeat (5) cyc();
        check("bp_addr", imem_address, 32'h2);
        check("bp_instr", dec.if_instr, 32'h1000);
        ready = 1'b1;
        repeat (3) cyc();
        ready = 1'b0;
        repeat (3) cyc();

        // redirect while full, lower bits of target ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0023;
        cyc();
        redirect_valid = 1'b0;
        check("redir_valid", dec.if_valid, 0);
        check("redir_addr", imem_address, 32'h8);
        cyc();
        check("redir_pc", dec.if_pc, 32'h20);
        check("redir_instr", dec.if_instr, 32'h1008);

        // redirect with a simultaneous pop
        repeat (2) cyc();
        ready          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        cyc();
        redirect_valid = 1'b0;
        check("rpop_valid", dec.if_valid, 0);
        cyc();
        check("rpop_pc", dec.if_pc, 32'h100);
        check("rpop_instr", dec.if_instr, 32'h1040);

        // fetch_en low drains the buffer without moving pc
        ready = 1'b0;
        repeat (3) cyc();
        fetch_en = 1'b0;
        ready    = 1'b1;
        repeat (3) cyc();
        check("drain_valid", dec.if_valid, 0);
        check("drain_instr", dec.if_instr, NOP_INSTR);
        check("drain_addr", imem_address, 32'h42);
        fetch_en = 1'b1;
        cyc();
        check("resume_addr", imem_address, 32'h43);

        // asynchronous reset between edges with a full buffer
        ready = 1'b0;
        repeat (3) cyc();
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", dec.if_valid, 0);
        check("arst_pc", dec.if_pc, 0);
        check("arst_addr", imem_address, 0);
        repeat (2) cyc();
        rst = 1'b0;

        // randomized traffic, including redirects near the top of the address space
        repeat (600) begin
            fetch_en       = ($urandom_range(0, 9) < 8);
            ready          = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                                         : $urandom;
            cyc();
        end

        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        ready          = 1'b1;
        repeat (4) cyc();
        check("final_idle", dec.if_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the program memory `memory`. That memory has a combinational, word-indexed read: `address` in, 32-bit `data_out` out.
- Holds the byte program counter and drives the memory word address from it.
- Captures each instruction with its PC into a 2-entry output buffer. Presents that buffer to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush any buffered instructions.

Parameters:
- ADDR_WIDTH, 32, width of PC and of the memory address port.
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_en  input  1  when low, no new fetch is issued; the buffer still drains.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  ADDR_WIDTH  target byte PC; bits [1:0] are ignored and treated as 0.
- imem_address  output  ADDR_WIDTH  word index to memory, equal to {2'b00, pc[ADDR_WIDTH-1:2]}.
- imem_data  input  32  memory `data_out`; valid combinationally in the same cycle.
- if_valid  output  1  buffer head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction; 32'h0000_0013 (NOP) when if_valid=0.
- if_pc  output  ADDR_WIDTH  byte PC of the head; 0 when if_valid=0.

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, buffer count=0, both entries cleared.
  - if_valid=0, if_instr=NOP, if_pc=0, imem_address=RESET_PC>>2.
- pop = if_valid & if_ready.
- push = fetch_en & ~redirect_valid & (count<2 | pop).
- On push:
  - Entry {pc, imem_data} is written at the tail.
  - pc <= pc+4, modulo 2^ADDR_WIDTH (wraps from all-ones-aligned to 0, no flag).
- Fetch-to-output latency: one cycle. The instruction fetched in cycle N appears on if_* after edge N.
- Buffer is a 2-entry FIFO with count 0..2, updated as count + push - pop.
- Full (count=2) with pop: push is allowed and count stays 2. Data order is preserved: the head advances and the new entry goes to the tail.
- Full without pop: no push; pc and imem_address hold.
- Empty with push: if_valid rises after the edge. No bypass from imem_data to the outputs.
- Redirect has priority over push and pop in the same cycle:
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - count <= 0, so all buffered entries are discarded.
  - No push that cycle.
  - A pop in the same cycle is still seen by decode (the handshake completed). Decode is responsible for squashing it.
- if_valid is low in the cycle after a redirect. The first instruction at the target appears one cycle later, so the redirect penalty is 2 cycles.
- fetch_en=0: pc holds and no push occurs; the buffer drains normally as decode pops.
- Asserting rst mid-operation discards all entries and any pending redirect.
- if_instr and if_pc are stable while if_valid=1 and if_ready=0.
- Outputs are driven from registers only. No combinational path from if_ready or redirect_valid to the if_* outputs.
- imem_address is a combinational function of pc only.

Decomposition:
- Package `fetch_pkg` holds:
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
  - FETCH_BUF_DEPTH = 2.
  - A packed struct `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_buf`: a 2-entry FIFO of fetch_entry_t with push, pop and flush, and full/empty/count outputs. Flush has priority over push.
- Top level holds the PC register, the push/pop logic and the memory address mapping.

Test Plan:
- Memory word k = 32'h0000_1000+k; rst 2 cycles, fetch_en=1, if_ready=1:
  - if_valid rises the first edge after reset release.
  - Observed sequence is (pc=0,instr=1000), (4,1001), (8,1002), (C,1003), with one new entry per cycle.
- Backpressure: if_ready=0 for 5 cycles after the first entry:
  - count saturates at 2 and pc stops at 8.
  - if_instr stays 32'h1000 throughout.
  - Release gives 1000, 1001, 1002 in order with no duplicate or skip.
- Redirect to 32'h0000_0023 while count=2:
  - Buffer flushed; if_valid=0 the next cycle.
  - Next valid entry is pc=0x20, instr=32'h1008.
  - imem_address=8 in the cycle after the redirect.
- Redirect and pop in the same cycle:
  - The popped entry is consumed once.
  - The old second entry never appears.
  - The target instruction follows after 2 cycles.
- fetch_en=0 with 2 buffered entries and if_ready=1:
  - Both entries drain, then if_valid=0 and if_instr=NOP.
  - pc does not change until fetch_en=1.
- Async reset asserted between edges with count=2: outputs drop immediately to if_valid=0, if_pc=0, and imem_address=RESET_PC>>2.
